// File: rtl/zigbee_pin_bridge_if.sv
// Signal bundle between the pad ring / modem core and the ZigBee pin bridge.
// The bridge uses the slave view; the pad/core side uses the master view.
interface zigbee_pin_bridge_if;
    logic [1:0]  sel_i;
    logic [21:0] mux_i;
    logic [17:0] mux_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;

    modport slave (
        input  sel_i, mux_i, tx_ready_i, rx_data_i, rx_valid_i,
        output mux_o, tx_data_o, tx_valid_o, rx_ready_o
    );

    modport master (
        output sel_i, mux_i, tx_ready_i, rx_data_i, rx_valid_i,
        input  mux_o, tx_data_o, tx_valid_o, rx_ready_o
    );
endinterface

// File: rtl/zigbee_pin_bridge.sv
// Pin bridge: synchronises the asynchronous pin bus, runs toggle handshakes
// into a TX FIFO / out of an RX FIFO, and multiplexes mux_o by pin mode.
//
// mode      | meaning
// MODE_TX   | pin strobe toggles push bytes into the TX FIFO
// MODE_RX   | RX FIFO head shown on the pins, host ack toggles pop it
// MODE_LOOP | synced pin bus looped back onto mux_o
// MODE_STAT | FIFO counts and sticky flags shown, mux_i[0] rise clears flags
module zigbee_pin_bridge #(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic                clk_i,
    input logic                resetn_i,
    zigbee_pin_bridge_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        MODE_TX   = 2'd0,
        MODE_RX   = 2'd1,
        MODE_LOOP = 2'd2,
        MODE_STAT = 2'd3
    } mode_t;

    logic [SYNC_STAGES-1:0][21:0] mux_sync;
    logic [SYNC_STAGES-1:0][1:0]  sel_sync;
    logic [21:0] s_mux;
    mode_t       s_sel;
    mode_t       sel_prev;
    mode_t       mode_q;
    mode_t       mode_d;

    logic tx_ref, ack_ref, clr_ref;
    logic tx_ack, rx_vtog, tx_ovf, rx_unf;
    logic [PW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
    logic [PW-1:0] tx_wr_d, tx_rd_d, rx_wr_d, rx_rd_d;
    logic [7:0] tx_mem [FIFO_DEPTH];
    logic [7:0] rx_mem [FIFO_DEPTH];
    logic [17:0] mux_q;
    logic [17:0] mux_d;

    logic steady, mode_load, refs_load;
    logic tx_empty, tx_full, rx_empty, rx_full;
    logic tx_tog, tx_push, tx_pop, rx_ack_tog, rx_push, rx_pop, stat_clr;
    logic tx_ack_d, rx_vtog_d, tx_ovf_d, rx_unf_d;
    logic [7:0] rx_head_d;
    logic unused_bits;

    function automatic logic [3:0] sat4(input logic [PW-1:0] cnt);
        logic [31:0] wide;
        wide = 32'(cnt);
        return (wide > 32'd15) ? 4'hF : wide[3:0];
    endfunction

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            mux_sync <= '0;
            sel_sync <= '0;
        end else begin
            mux_sync[0] <= bus.mux_i;
            sel_sync[0] <= bus.sel_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                mux_sync[i] <= mux_sync[i-1];
                sel_sync[i] <= sel_sync[i-1];
            end
        end
    end

    assign s_mux       = mux_sync[SYNC_STAGES-1];
    assign s_sel       = mode_t'(sel_sync[SYNC_STAGES-1]);
    assign unused_bits = ^s_mux[21:18];

    // Pin actions only while the synced selector agrees with the mode, so a
    // toggle racing a mode change is absorbed by the ref reload instead.
    assign steady    = (s_sel == mode_q) && (sel_prev == mode_q);
    assign mode_load = (s_sel == sel_prev) && (s_sel != mode_q);

    assign tx_empty = (tx_wr == tx_rd);
    assign tx_full  = (tx_wr[AW] != tx_rd[AW]) && (tx_wr[AW-1:0] == tx_rd[AW-1:0]);
    assign rx_empty = (rx_wr == rx_rd);
    assign rx_full  = (rx_wr[AW] != rx_rd[AW]) && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);

    assign tx_pop     = !tx_empty && bus.tx_ready_i;
    assign tx_tog     = steady && (mode_q == MODE_TX) && (s_mux[8] != tx_ref);
    assign tx_push    = tx_tog && (!tx_full || tx_pop);
    assign rx_ack_tog = steady && (mode_q == MODE_RX) && (s_mux[9] != ack_ref);
    assign rx_pop     = rx_ack_tog && !rx_empty;
    assign rx_push    = bus.rx_valid_i && (!rx_full || rx_pop);
    assign stat_clr   = steady && (mode_q == MODE_STAT) && s_mux[0] && !clr_ref;

    assign tx_wr_d = tx_wr + PW'(tx_push);
    assign tx_rd_d = tx_rd + PW'(tx_pop);
    assign rx_wr_d = rx_wr + PW'(rx_push);
    assign rx_rd_d = rx_rd + PW'(rx_pop);

    assign tx_ack_d  = tx_ack ^ tx_push;
    assign rx_vtog_d = rx_vtog ^ ((rx_empty && rx_push) || (rx_pop && (rx_wr_d != rx_rd_d)));
    assign tx_ovf_d  = (tx_ovf | (tx_tog && !tx_push)) & ~stat_clr;
    assign rx_unf_d  = (rx_unf | (rx_ack_tog && rx_empty)) & ~stat_clr;
    // A byte pushed into the slot that becomes the head is not in memory yet.
    assign rx_head_d = (rx_push && (rx_wr == rx_rd_d)) ? bus.rx_data_i : rx_mem[rx_rd_d[AW-1:0]];

    always_comb begin
        mode_d    = mode_q;
        refs_load = steady || mode_load;
        mux_d     = '0;
        if (mode_load) mode_d = s_sel;
        case (mode_d)
            MODE_TX:   mux_d = {15'd0, tx_ovf_d,
                                (tx_wr_d[AW] != tx_rd_d[AW]) && (tx_wr_d[AW-1:0] == tx_rd_d[AW-1:0]),
                                tx_ack_d};
            MODE_RX:   mux_d = {8'd0, (rx_wr_d == rx_rd_d), rx_vtog_d, rx_head_d};
            MODE_LOOP: mux_d = s_mux[17:0];
            MODE_STAT: mux_d = {8'd0, rx_unf_d, tx_ovf_d,
                                sat4(rx_wr_d - rx_rd_d), sat4(tx_wr_d - tx_rd_d)};
            default:   mux_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            mode_q   <= MODE_TX;
            sel_prev <= MODE_TX;
            tx_ref   <= 1'b0;
            ack_ref  <= 1'b0;
            clr_ref  <= 1'b0;
            tx_wr    <= '0;
            tx_rd    <= '0;
            rx_wr    <= '0;
            rx_rd    <= '0;
            tx_ack   <= 1'b0;
            rx_vtog  <= 1'b0;
            tx_ovf   <= 1'b0;
            rx_unf   <= 1'b0;
            mux_q    <= '0;
        end else begin
            mode_q   <= mode_d;
            sel_prev <= s_sel;
            if (refs_load) begin
                tx_ref  <= s_mux[8];
                ack_ref <= s_mux[9];
                clr_ref <= s_mux[0];
            end
            tx_wr   <= tx_wr_d;
            tx_rd   <= tx_rd_d;
            rx_wr   <= rx_wr_d;
            rx_rd   <= rx_rd_d;
            tx_ack  <= tx_ack_d;
            rx_vtog <= rx_vtog_d;
            tx_ovf  <= tx_ovf_d;
            rx_unf  <= rx_unf_d;
            mux_q   <= mux_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wr[AW-1:0]] <= s_mux[7:0];
        if (rx_push) rx_mem[rx_wr[AW-1:0]] <= bus.rx_data_i;
    end

    assign bus.mux_o      = mux_q;
    assign bus.tx_valid_o = !tx_empty;
    assign bus.tx_data_o  = tx_mem[tx_rd[AW-1:0]];
    assign bus.rx_ready_o = !rx_full;
endmodule
